// File: rtl/decryptor.sv
// Cipher-store decryptor: recovers a 4-bit number from a stored ciphertext by
// restoring division with the key, then undoing the encryptor's 2-bit rotate.
module decryptor #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        key,
  output logic              busy,
  output logic              done,
  output logic [3:0]        num_out,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, DIV, FIN} state_t;

  state_t state, state_next;

  logic [7:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        key_q;
  logic [7:0]        dvd;
  logic [7:0]        quo;
  logic [4:0]        rem;
  logic [2:0]        step;

  logic [4:0] rem_sh;
  logic       take;
  logic [4:0] rem_new;
  logic       fin_err;

  // Store is deliberately not reset so contents survive an aborted operation.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = DIV;
      DIV:     if (step == 3'd7) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    rem_sh  = {rem[3:0], dvd[7]};
    take    = (rem_sh >= {1'b0, key_q});
    rem_new = take ? (rem_sh - {1'b0, key_q}) : rem_sh;
    fin_err = (key_q == 4'd0) || (rem != 5'd0) || (|quo[7:4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      key_q  <= '0;
      dvd    <= '0;
      quo    <= '0;
      rem    <= '0;
      step   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q <= rd_addr;
            key_q  <= key;
          end
        end
        FETCH: begin
          dvd  <= mem[addr_q];
          rem  <= '0;
          quo  <= '0;
          step <= '0;
        end
        DIV: begin
          rem  <= rem_new;
          dvd  <= {dvd[6:0], 1'b0};
          quo  <= {quo[6:0], take};
          step <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      num_out <= '0;
      err     <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        err     <= fin_err;
        num_out <= fin_err ? 4'd0 : {quo[1:0], quo[3:2]};
      end
    end
  end

endmodule

// File: doc/decryptor.md
DECRYPTOR -- requirements
Module: decryptor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning the cipher-store address width; store depth is 2**ADDR_W entries of 8 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_en, input, 1 bit: write strobe into the cipher store.
REQ-005 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-006 The block SHALL have port wr_data, input, 8 bits: ciphertext (encryptor product) to store.
REQ-007 The block SHALL have port start, input, 1 bit: decrypt request, sampled only in IDLE.
REQ-008 The block SHALL have port rd_addr, input, ADDR_W bits: store entry to decrypt, sampled with start.
REQ-009 The block SHALL have port key, input, 4 bits: decryption key, sampled with start.
REQ-010 The block SHALL have port busy, output, 1 bit: high in FETCH, DIV and FIN.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking num_out/err valid.
REQ-012 The block SHALL have port num_out, output, 4 bits: recovered plaintext number.
REQ-013 The block SHALL have port err, output, 1 bit: ciphertext not decodable with key.

Function
REQ-014 Decryption SHALL invert the encryptor: q = cipher / key (unsigned), num_out = {q[1:0], q[3:2]}, i.e. rotate q by two bit positions.
REQ-015 The cipher store SHALL accept a write on any rising edge with wr_en=1, independent of FSM state.
REQ-016 The FSM SHALL have states IDLE, FETCH, DIV and FIN: IDLE->FETCH on start=1; FETCH->DIV unconditionally; DIV->FIN after the 8th step; FIN->IDLE unconditionally.
REQ-017 On the edge accepting start (T0), the block SHALL latch rd_addr and key; start in any other state SHALL be ignored.
REQ-018 In FETCH, the edge T1 SHALL load the dividend from store[rd_addr], clear the remainder and clear the step counter.
REQ-019 In DIV, each edge T2..T9 SHALL perform one restoring-division step: shift {rem, dividend} left by 1, subtract key from rem when rem >= key, and shift the result bit into the quotient; remainder is 5 bits and quotient is 8 bits.
REQ-020 Edge T10 (FIN->IDLE) SHALL register num_out and err and set done=1; edge T11 SHALL clear done; total latency SHALL be 10 cycles from the start edge to done high.
REQ-021 err SHALL be set when key==0, the final remainder != 0, or q > 15.
REQ-022 When err=1, num_out SHALL be 0.
REQ-023 num_out and err SHALL hold their values until the next done pulse or reset.
REQ-024 busy SHALL fall on the same edge that done rises.
REQ-025 When wr_en and start coincide in IDLE at T0 on the same address, FETCH SHALL read the newly written value.
REQ-026 A write at T1 or later to the address being decrypted SHALL NOT affect the result in progress.
REQ-027 key and rd_addr changes after T0 SHALL NOT affect the operation in progress.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and drive busy=0, done=0, num_out=0 and err=0, including when an operation is in progress; the aborted operation SHALL produce no done pulse.
REQ-029 Reset SHALL NOT clear cipher-store contents; store contents are undefined until written.
REQ-030 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 The bench SHALL write store[0]=0x10, then start with rd_addr=0, key=4'b1000, and require done exactly 10 cycles after the start edge with num_out=4'b1000 and err=0.
REQ-032 The bench SHALL back-to-back decrypt 0x30/key 8, 0x1E/key 10 and 0xC4/key 14, and require num_out = 1001, 1100 and 1011 respectively, each with err=0.
REQ-033 The bench SHALL decrypt 0x1F with key 10 and require err=1 and num_out=0 (remainder 1); it SHALL decrypt 0xF0 with key 1 and require err=1 (q=240); it SHALL decrypt with key 0 and require err=1.
REQ-034 The bench SHALL pulse start during DIV and require no effect; it SHALL write the active address at T3 and require the original result.
REQ-035 The bench SHALL assert rst_n=0 at T5 and require busy=0 immediately with no done pulse, then write 0x10 and start a new decrypt with key 8, require the correct result (num_out=1000), and require that store contents written before the reset are unchanged.
